// File: rtl/tmr_resp_distributor.sv
// Forwards the voted OBI request under an outstanding limit and fans the bus
// response out to every lockstep hart; drains and halts on a voter mismatch.
module tmr_resp_distributor #(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   voted_req_i,
    input  logic [31:0]            voted_addr_i,
    input  logic                   voted_we_i,
    input  logic [3:0]             voted_be_i,
    input  logic [31:0]            voted_wdata_i,
    input  logic                   error_i,
    input  logic [NHARTS-1:0]      error_id_i,
    output logic                   bus_req_o,
    output logic [31:0]            bus_addr_o,
    output logic                   bus_we_o,
    output logic [3:0]             bus_be_o,
    output logic [31:0]            bus_wdata_o,
    input  logic                   bus_gnt_i,
    input  logic                   bus_rvalid_i,
    input  logic [31:0]            bus_rdata_i,
    output logic [NHARTS-1:0]      core_gnt_o,
    output logic [NHARTS-1:0]      core_rvalid_o,
    output logic [NHARTS*32-1:0]   core_rdata_o,
    output logic [NHARTS-1:0]      fault_mask_o,
    output logic                   recovery_req_o,
    input  logic                   recovery_ack_i,
    output logic [CNT_W-1:0]       outstanding_o,
    output logic                   protocol_err_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [NHARTS-1:0]   r_mask;
    logic [NHARTS-1:0]   w_mask_next;
    logic                r_proto_err;
    logic                r_recovery;
    logic                w_issue;
    logic                w_gnt_eff;
    logic                w_rsp_dec;
    logic                w_spurious;

    assign w_issue = (r_state == RUN) && !error_i && (r_cnt < MAX_CNT);

    assign bus_req_o   = voted_req_i & w_issue;
    assign bus_addr_o  = voted_addr_i;
    assign bus_we_o    = voted_we_i;
    assign bus_be_o    = voted_be_i;
    assign bus_wdata_o = voted_wdata_i;

    assign w_gnt_eff  = bus_gnt_i & bus_req_o;
    assign w_rsp_dec  = bus_rvalid_i && (r_cnt != '0);
    assign w_spurious = bus_rvalid_i && (r_cnt == '0);

    // Every hart gets the same response, masked or not, to stay in lockstep
    assign core_gnt_o    = {NHARTS{w_gnt_eff}};
    assign core_rvalid_o = {NHARTS{bus_rvalid_i}};
    assign core_rdata_o  = {NHARTS{bus_rdata_i}};

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_gnt_eff && !w_rsp_dec) begin
            w_cnt_next = r_cnt + 1'b1;
        end else if (!w_gnt_eff && w_rsp_dec) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = error_i ? (r_mask | error_id_i) : r_mask;
        case (r_state)
            RUN: begin
                if (error_i) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_cnt_next == '0) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                if (recovery_ack_i) begin
                    w_state_next = RUN;
                    w_mask_next  = '0;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_proto_err <= 1'b0;
            r_recovery  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_mask      <= w_mask_next;
            r_proto_err <= r_proto_err | w_spurious;
            r_recovery  <= (w_state_next == HALT);
        end
    end

    assign fault_mask_o   = r_mask;
    assign recovery_req_o = r_recovery;
    assign outstanding_o  = r_cnt;
    assign protocol_err_o = r_proto_err;

endmodule

// File: tb/tb_tmr_resp_distributor.sv
// Scoreboard bench for tmr_resp_distributor: grants push expected read data,
// every rvalid pops it and checks that all three harts see the same response.
module tb_tmr_resp_distributor;

    logic          clk_i;
    logic          rst_ni;
    logic          voted_req_i;
    logic [31:0]   voted_addr_i;
    logic          voted_we_i;
    logic [3:0]    voted_be_i;
    logic [31:0]   voted_wdata_i;
    logic          error_i;
    logic [2:0]    error_id_i;
    logic          bus_req_o;
    logic [31:0]   bus_addr_o;
    logic          bus_we_o;
    logic [3:0]    bus_be_o;
    logic [31:0]   bus_wdata_o;
    logic          bus_gnt_i;
    logic          bus_rvalid_i;
    logic [31:0]   bus_rdata_i;
    logic [2:0]    core_gnt_o;
    logic [2:0]    core_rvalid_o;
    logic [95:0]   core_rdata_o;
    logic [2:0]    fault_mask_o;
    logic          recovery_req_o;
    logic          recovery_ack_i;
    logic [1:0]    outstanding_o;
    logic          protocol_err_o;

    int checks;
    int failures;
    int gidx;
    int ridx;
    logic [31:0] exp_q[$];
    logic [31:0] tbl[8];

    tmr_resp_distributor #(
        .NHARTS(3),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .voted_req_i(voted_req_i),
        .voted_addr_i(voted_addr_i),
        .voted_we_i(voted_we_i),
        .voted_be_i(voted_be_i),
        .voted_wdata_i(voted_wdata_i),
        .error_i(error_i),
        .error_id_i(error_id_i),
        .bus_req_o(bus_req_o),
        .bus_addr_o(bus_addr_o),
        .bus_we_o(bus_we_o),
        .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i),
        .core_gnt_o(core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o),
        .fault_mask_o(fault_mask_o),
        .recovery_req_o(recovery_req_o),
        .recovery_ack_i(recovery_ack_i),
        .outstanding_o(outstanding_o),
        .protocol_err_o(protocol_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Bus model plus scoreboard: rvalid pops, an expected grant pushes
    task automatic drive(input logic req, input logic gnt, input logic rv,
                         input logic err, input logic [2:0] eid,
                         input logic ack, input logic exp_gnt,
                         input string tag);
        logic [31:0] e;
        voted_req_i    = req;
        bus_gnt_i      = gnt;
        bus_rvalid_i   = rv;
        error_i        = err;
        error_id_i     = eid;
        recovery_ack_i = ack;
        bus_rdata_i    = 32'h0;
        if (rv) begin
            bus_rdata_i = (ridx < gidx) ? tbl[ridx % 8] : 32'hBAD0BAD0;
        end
        #1;
        checks++;
        if (core_gnt_o !== {3{exp_gnt}}) begin
            failures++;
            $display("FAIL %s core_gnt got=%b exp=%b", tag, core_gnt_o,
                     {3{exp_gnt}});
        end
        if (rv) begin
            checks++;
            if (core_rvalid_o !== 3'b111) begin
                failures++;
                $display("FAIL %s core_rvalid got=%b exp=111", tag,
                         core_rvalid_o);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ridx++;
                for (int h = 0; h < 3; h++) begin
                    checks++;
                    if (core_rdata_o[h*32 +: 32] !== e) begin
                        failures++;
                        $display("FAIL %s rdata hart%0d got=%h exp=%h", tag,
                                 h, core_rdata_o[h*32 +: 32], e);
                    end
                end
            end
        end
        if (exp_gnt) begin
            exp_q.push_back(tbl[gidx % 8]);
            gidx++;
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "rst_in");
        tick;
        rst_ni = 1'b1;
        checks++;
        if (outstanding_o !== 2'd0 || fault_mask_o !== 3'b000 ||
            recovery_req_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset got=%0d/%b/%b/%b exp=0/000/0/0",
                     outstanding_o, fault_mask_o, recovery_req_o,
                     protocol_err_o);
        end
        voted_addr_i  = 32'hA000_0040;
        voted_we_i    = 1'b1;
        voted_be_i    = 4'h5;
        voted_wdata_i = 32'hCAFE_F00D;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "rst_run");
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'hA000_0040 ||
            bus_we_o !== 1'b1 || bus_be_o !== 4'h5 ||
            bus_wdata_o !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL passthru got=%b %h %b %h %h", bus_req_o,
                     bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o);
        end
        voted_we_i = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, "b2b_g0");
        tick;
        checks++;
        if (outstanding_o !== 2'd1) begin
            failures++;
            $display("FAIL b2b_cnt1 got=%0d exp=1", outstanding_o);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, "b2b_g1");
        tick;
        checks++;
        if (outstanding_o !== 2'd1) begin
            failures++;
            $display("FAIL b2b_peak got=%0d exp=1", outstanding_o);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, "b2b_r1");
        tick;
        checks++;
        if (outstanding_o !== 2'd0) begin
            failures++;
            $display("FAIL b2b_cnt0 got=%0d exp=0", outstanding_o);
        end
    endtask

    task automatic test_limit;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, "lim_g0");
        tick;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, "lim_g1");
        tick;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "lim_blk");
        checks++;
        if (bus_req_o !== 1'b0 || outstanding_o !== 2'd2) begin
            failures++;
            $display("FAIL lim_blk got=req%b cnt%0d exp=req0 cnt2",
                     bus_req_o, outstanding_o);
        end
        tick;
        checks++;
        if (outstanding_o !== 2'd2) begin
            failures++;
            $display("FAIL lim_nocount got=%0d exp=2", outstanding_o);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, "lim_r0");
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "lim_reen");
        checks++;
        if (bus_req_o !== 1'b1 || outstanding_o !== 2'd1) begin
            failures++;
            $display("FAIL lim_reen got=req%b cnt%0d exp=req1 cnt1",
                     bus_req_o, outstanding_o);
        end
    endtask

    task automatic test_fault_two;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, "f2_g");
        tick;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, "f2_err");
        checks++;
        if (bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL f2_block got=%b exp=0", bus_req_o);
        end
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "f2_drain");
        checks++;
        if (fault_mask_o !== 3'b010 || bus_req_o !== 1'b0 ||
            recovery_req_o !== 1'b0 || outstanding_o !== 2'd2) begin
            failures++;
            $display("FAIL f2_drain got=%b req%b rec%b cnt%0d", fault_mask_o,
                     bus_req_o, recovery_req_o, outstanding_o);
        end
        tick;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, "f2_r0");
        tick;
        checks++;
        if (recovery_req_o !== 1'b0 || outstanding_o !== 2'd1) begin
            failures++;
            $display("FAIL f2_mid got=rec%b cnt%0d exp=rec0 cnt1",
                     recovery_req_o, outstanding_o);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, "f2_r1");
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "f2_halt");
        checks++;
        if (recovery_req_o !== 1'b1 || outstanding_o !== 2'd0 ||
            bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL f2_halt got=rec%b cnt%0d req%b exp=1 0 0",
                     recovery_req_o, outstanding_o, bus_req_o);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, "f2_ack");
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "f2_run");
        checks++;
        if (recovery_req_o !== 1'b0 || fault_mask_o !== 3'b000 ||
            bus_req_o !== 1'b1) begin
            failures++;
            $display("FAIL f2_run got=rec%b mask%b req%b exp=0 000 1",
                     recovery_req_o, fault_mask_o, bus_req_o);
        end
    endtask

    task automatic test_simul;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, "sim_ack");
        tick;
        checks++;
        if (recovery_req_o !== 1'b0 || outstanding_o !== 2'd0) begin
            failures++;
            $display("FAIL sim_ackign got=rec%b cnt%0d exp=0 0",
                     recovery_req_o, outstanding_o);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, "sim_g0");
        tick;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, "sim_both");
        tick;
        checks++;
        if (outstanding_o !== 2'd1) begin
            failures++;
            $display("FAIL sim_both got=%0d exp=1", outstanding_o);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, "sim_r");
        tick;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, "sim_spur");
        tick;
        checks++;
        if (protocol_err_o !== 1'b1 || outstanding_o !== 2'd0) begin
            failures++;
            $display("FAIL sim_spur got=perr%b cnt%0d exp=1 0",
                     protocol_err_o, outstanding_o);
        end
    endtask

    task automatic test_fault_zero;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, "f0_err");
        checks++;
        if (bus_req_o !== 1'b0) begin
            failures++;
            $display("FAIL f0_block got=%b exp=0", bus_req_o);
        end
        tick;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "f0_drain");
        checks++;
        if (recovery_req_o !== 1'b0 || fault_mask_o !== 3'b100) begin
            failures++;
            $display("FAIL f0_drain got=rec%b mask%b exp=0 100",
                     recovery_req_o, fault_mask_o);
        end
        tick;
        checks++;
        if (recovery_req_o !== 1'b1) begin
            failures++;
            $display("FAIL f0_halt got=%b exp=1", recovery_req_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, "f0_err2");
        tick;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "f0_hold");
        tick;
        checks++;
        if (recovery_req_o !== 1'b1 || fault_mask_o !== 3'b101) begin
            failures++;
            $display("FAIL f0_sticky got=rec%b mask%b exp=1 101",
                     recovery_req_o, fault_mask_o);
        end
    endtask

    task automatic test_reset_halt;
        rst_ni = 1'b0;
        tick;
        rst_ni = 1'b1;
        checks++;
        if (outstanding_o !== 2'd0 || fault_mask_o !== 3'b000 ||
            recovery_req_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_halt got=%0d/%b/%b/%b exp=0/000/0/0",
                     outstanding_o, fault_mask_o, recovery_req_o,
                     protocol_err_o);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, "rst_run2");
        checks++;
        if (bus_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_run2 req got=%b exp=1", bus_req_o);
        end
        tick;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, "rst_r");
        tick;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        gidx     = 0;
        ridx     = 0;
        tbl[0] = 32'hDEADBEEF;
        tbl[1] = 32'h12345678;
        tbl[2] = 32'h0BADF00D;
        tbl[3] = 32'hFFFF0000;
        tbl[4] = 32'h00000001;
        tbl[5] = 32'hA5A5A5A5;
        tbl[6] = 32'h5A5A5A5A;
        tbl[7] = 32'h80000000;
        rst_ni         = 1'b0;
        voted_req_i    = 1'b0;
        voted_addr_i   = 32'h0;
        voted_we_i     = 1'b0;
        voted_be_i     = 4'hF;
        voted_wdata_i  = 32'h0;
        error_i        = 1'b0;
        error_id_i     = 3'b000;
        bus_gnt_i      = 1'b0;
        bus_rvalid_i   = 1'b0;
        bus_rdata_i    = 32'h0;
        recovery_ack_i = 1'b0;
        tick;
        test_reset;
        test_back_to_back;
        test_limit;
        test_fault_two;
        test_simul;
        test_fault_zero;
        test_reset_halt;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
